nexus_nonce_dispatch: RTL and testbench

//  Sits downstream of the SK1024 pipeline (FirstSkeinRound -> SecondSkeinRound -> NexusKeccak1024).

---
 rtl/nexus_pow_pkg.sv | 24 ++
 rtl/nexus_found_fifo.sv | 80 ++++++++
 rtl/nexus_nonce_dispatch.sv | 131 +++++++++++++
 tb/tb_nexus_nonce_dispatch.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nexus_pow_pkg.sv
// Shared constants for the SK1024 proof-of-work datapath: stage counts,
// total pipeline latency and the nonce dispatcher state encoding.
package nexus_pow_pkg;

  localparam int SKEIN_ROUNDS    = 80;
  localparam int SKEIN_KEYINJ    = 21;
  localparam int SKEINRNDSTAGES  = SKEIN_ROUNDS;
  localparam int SKEINKEYSTAGES  = 2 * SKEIN_KEYINJ;
  localparam int SKEINBLKSTAGES  = SKEINRNDSTAGES + SKEINKEYSTAGES;
  localparam int KECCAK_ROUNDS   = 24;
  localparam int KECCAKRNDSTAGES = 2 * KECCAK_ROUNDS;

  // Two Skein blocks, three Keccak blocks, plus input and output registers.
  localparam int TOTALSTAGES = 2 * SKEINBLKSTAGES + 3 * KECCAKRNDSTAGES + 2;

  localparam int NONCE_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } disp_state_e;

endpackage

// File: rtl/nexus_found_fifo.sv
// Small synchronous FIFO for found nonces; the head entry and its valid flag
// are held in registers so the host sees flop outputs.
module nexus_found_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             HashRst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty
);
  import nexus_pow_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    head_d  = valid_d ? mem_d[rd_ptr_d] : head_q;
  end

  always_ff @(posedge clk) begin
    if (HashRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = head_q;
  assign valid = valid_q;

endmodule

// File: rtl/nexus_nonce_dispatch.sv
// Issues consecutive nonces into the SK1024 pipeline, tracks the emerging
// nonce with a valid chain plus trailing counter, and queues target hits.
module nexus_nonce_dispatch #(
  parameter int TOTALSTAGES = nexus_pow_pkg::TOTALSTAGES,
  parameter int NONCE_W     = nexus_pow_pkg::NONCE_W,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               HashRst,
  input  logic               Start,
  input  logic               Stop,
  input  logic [NONCE_W-1:0] NonceStart,
  input  logic [NONCE_W-1:0] NonceEnd,
  input  logic [NONCE_W-1:0] Target,
  output logic [NONCE_W-1:0] CurNonce,
  output logic               NonceValid,
  input  logic [NONCE_W-1:0] KeccakOutputQword,
  output logic [NONCE_W-1:0] FoundNonce,
  output logic               FoundValid,
  input  logic               FoundReady,
  output logic               Overflow,
  output logic               Busy,
  output logic               Done
);
  import nexus_pow_pkg::*;

  disp_state_e              state_q, state_d;
  logic [NONCE_W-1:0]       cur_nonce_q, cur_nonce_d;
  logic [NONCE_W-1:0]       end_nonce_q, end_nonce_d;
  logic [NONCE_W-1:0]       out_nonce_q, out_nonce_d;
  logic                     nonce_valid_q, nonce_valid_d;
  logic                     overflow_q, overflow_d;
  logic                     done_q, done_d;
  logic [TOTALSTAGES-1:0]   chain_q, chain_d;
  logic                     tail, hit;
  logic                     fifo_full, fifo_empty, fifo_valid, fifo_pop;

  assign tail     = chain_q[TOTALSTAGES-1];
  assign hit      = tail & (KeccakOutputQword <= Target);
  assign fifo_pop = FoundReady & ~fifo_empty;

  always_comb begin
    state_d       = state_q;
    cur_nonce_d   = cur_nonce_q;
    end_nonce_d   = end_nonce_q;
    out_nonce_d   = out_nonce_q;
    nonce_valid_d = nonce_valid_q;
    overflow_d    = overflow_q;
    done_d        = 1'b0;
    chain_d       = {chain_q[TOTALSTAGES-2:0], nonce_valid_q};

    // The trailing counter replaces a nonce-wide delay line: issue order is
    // preserved, so it only needs to advance when a valid result emerges.
    if (tail) out_nonce_d = out_nonce_q + 1'b1;
    if (hit && fifo_full && !fifo_pop) overflow_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d       = ST_RUN;
          cur_nonce_d   = NonceStart;
          end_nonce_d   = NonceEnd;
          out_nonce_d   = NonceStart;
          nonce_valid_d = 1'b1;
          overflow_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (Stop || (cur_nonce_q == end_nonce_q)) begin
          state_d       = ST_DRAIN;
          nonce_valid_d = 1'b0;
        end else begin
          cur_nonce_d = cur_nonce_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (chain_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (HashRst) begin
      state_q       <= ST_IDLE;
      cur_nonce_q   <= '0;
      nonce_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
      chain_q       <= '0;
    end else begin
      state_q       <= state_d;
      cur_nonce_q   <= cur_nonce_d;
      nonce_valid_q <= nonce_valid_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
      chain_q       <= chain_d;
    end
  end

  always_ff @(posedge clk) begin
    end_nonce_q <= end_nonce_d;
    out_nonce_q <= out_nonce_d;
  end

  nexus_found_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_found_fifo (
    .clk     (clk),
    .HashRst (HashRst),
    .push    (hit),
    .pop     (fifo_pop),
    .din     (out_nonce_q),
    .dout    (FoundNonce),
    .valid   (fifo_valid),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign CurNonce   = cur_nonce_q;
  assign NonceValid = nonce_valid_q;
  assign FoundValid = fifo_valid;
  assign Overflow   = overflow_q;
  assign Busy       = (state_q != ST_IDLE);
  assign Done       = done_q;

endmodule

// File: tb/tb_nexus_nonce_dispatch.sv
// Directed bench for nexus_nonce_dispatch with a delay-line stand-in for the
// hash pipeline whose result per nonce is selected by the active mode.
module tb_nexus_nonce_dispatch;

  localparam int TS = 390;
  localparam int MODE_NONE  = 0;
  localparam int MODE_REAL  = 1;
  localparam int MODE_HIT10 = 2;
  localparam int MODE_ALL   = 3;
  localparam int MODE_IDENT = 4;

  logic        clk = 1'b0;
  logic        HashRst = 1'b1;
  logic        Start = 1'b0;
  logic        Stop = 1'b0;
  logic [63:0] NonceStart = '0;
  logic [63:0] NonceEnd = '0;
  logic [63:0] Target = '0;
  logic [63:0] CurNonce;
  logic        NonceValid;
  logic [63:0] KeccakOutputQword;
  logic [63:0] FoundNonce;
  logic        FoundValid;
  logic        FoundReady = 1'b0;
  logic        Overflow;
  logic        Busy;
  logic        Done;

  int n_total = 0;
  int n_pass  = 0;
  int mode    = MODE_NONE;

  logic [63:0] dly [TS];

  nexus_nonce_dispatch #(
    .TOTALSTAGES (TS),
    .NONCE_W     (64),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk               (clk),
    .HashRst           (HashRst),
    .Start             (Start),
    .Stop              (Stop),
    .NonceStart        (NonceStart),
    .NonceEnd          (NonceEnd),
    .Target            (Target),
    .CurNonce          (CurNonce),
    .NonceValid        (NonceValid),
    .KeccakOutputQword (KeccakOutputQword),
    .FoundNonce        (FoundNonce),
    .FoundValid        (FoundValid),
    .FoundReady        (FoundReady),
    .Overflow          (Overflow),
    .Busy              (Busy),
    .Done              (Done)
  );

  always #5 clk = ~clk;

  // Pipeline stand-in: the result seen now belongs to the nonce issued TS cycles ago.
  always @(posedge clk) begin
    dly[0] <= CurNonce;
    for (int i = 1; i < TS; i++) dly[i] <= dly[i-1];
  end

  always_comb begin
    case (mode)
      MODE_REAL:  KeccakOutputQword = (dly[TS-1] == 64'h00000001FCAFC044) ? 64'h000000000000ABCD : '1;
      MODE_HIT10: KeccakOutputQword = (dly[TS-1] == 64'h10) ? 64'h0 : '1;
      MODE_ALL:   KeccakOutputQword = 64'h0;
      MODE_IDENT: KeccakOutputQword = dly[TS-1];
      default:    KeccakOutputQword = '1;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [63:0] s, input logic [63:0] e);
    NonceStart = s;
    NonceEnd   = e;
    Start      = 1'b1;
    tick();
    Start      = 1'b0;
  endtask

  task automatic pop_one();
    FoundReady = 1'b1;
    tick();
    FoundReady = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 800 && !seen; i++) begin
      tick();
      if (Done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    HashRst = 1'b1;
    tick();
    tick();
    n_total++; if (CurNonce !== 64'h0) $display("FAIL rst_cur: got %h want %h", CurNonce, 64'h0); else n_pass++;
    n_total++; if (NonceValid !== 1'b0) $display("FAIL rst_nv: got %b want 0", NonceValid); else n_pass++;
    n_total++; if (FoundValid !== 1'b0) $display("FAIL rst_fv: got %b want 0", FoundValid); else n_pass++;
    n_total++; if (FoundNonce !== 64'h0) $display("FAIL rst_fn: got %h want 0", FoundNonce); else n_pass++;
    n_total++; if (Overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", Overflow); else n_pass++;
    n_total++; if (Busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", Busy); else n_pass++;
    n_total++; if (Done !== 1'b0) $display("FAIL rst_done: got %b want 0", Done); else n_pass++;
    HashRst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int cyc;
    mode   = MODE_REAL;
    Target = 64'h00000000FFFFFFFF;
    start_run(64'h00000001FCAFC044, 64'h00000001FCAFC044);
    n_total++; if (CurNonce !== 64'h00000001FCAFC044) $display("FAIL single_cur: got %h want %h", CurNonce, 64'h00000001FCAFC044); else n_pass++;
    n_total++; if ({NonceValid, Busy} !== 2'b11) $display("FAIL single_issue: got nv/busy %b want 11", {NonceValid, Busy}); else n_pass++;
    tick();
    n_total++; if (NonceValid !== 1'b0) $display("FAIL single_nv_off: got %b want 0", NonceValid); else n_pass++;
    cyc = 1;
    while (!FoundValid && cyc < 600) begin
      tick();
      cyc++;
    end
    n_total++; if (cyc !== 391) $display("FAIL single_latency: got %0d want 391", cyc); else n_pass++;
    n_total++; if (FoundNonce !== 64'h00000001FCAFC044) $display("FAIL single_found: got %h want %h", FoundNonce, 64'h00000001FCAFC044); else n_pass++;
    n_total++; if (Done !== 1'b0) $display("FAIL single_done_early: got %b want 0", Done); else n_pass++;
    tick();
    n_total++; if ({Done, Busy} !== 2'b10) $display("FAIL single_done: got done/busy %b want 10", {Done, Busy}); else n_pass++;
    tick();
    n_total++; if (Done !== 1'b0) $display("FAIL single_done_pulse: got %b want 0", Done); else n_pass++;
    pop_one();
    n_total++; if (FoundValid !== 1'b0) $display("FAIL single_pop: got %b want 0", FoundValid); else n_pass++;
  endtask

  task automatic test_range();
    int nv;
    logic [63:0] last;
    bit seen;
    mode   = MODE_HIT10;
    Target = 64'h0;
    start_run(64'h0, 64'h1F);
    nv = 0;
    last = '0;
    while (NonceValid && nv < 100) begin
      last = CurNonce;
      nv++;
      tick();
    end
    n_total++; if (nv !== 32) $display("FAIL range_count: got %0d want 32", nv); else n_pass++;
    n_total++; if (last !== 64'h1F) $display("FAIL range_last: got %h want %h", last, 64'h1F); else n_pass++;
    wait_done(seen);
    n_total++; if (seen !== 1'b1) $display("FAIL range_done: got %b want 1", seen); else n_pass++;
    n_total++; if ({FoundValid, FoundNonce} !== {1'b1, 64'h10}) $display("FAIL range_found: got %b/%h want 1/%h", FoundValid, FoundNonce, 64'h10); else n_pass++;
    pop_one();
    n_total++; if (FoundValid !== 1'b0) $display("FAIL range_only_one: got %b want 0", FoundValid); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [63:0] exp_n [4];
    bit seen;
    exp_n = '{64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h1};
    mode   = MODE_ALL;
    Target = 64'h0;
    start_run(64'hFFFFFFFFFFFFFFFE, 64'h1);
    for (int i = 0; i < 4; i++) begin
      n_total++; if ({NonceValid, CurNonce} !== {1'b1, exp_n[i]}) $display("FAIL wrap_issue%0d: got %b/%h want 1/%h", i, NonceValid, CurNonce, exp_n[i]); else n_pass++;
      tick();
    end
    n_total++; if (NonceValid !== 1'b0) $display("FAIL wrap_end: got %b want 0", NonceValid); else n_pass++;
    wait_done(seen);
    for (int i = 0; i < 4; i++) begin
      n_total++; if ({FoundValid, FoundNonce} !== {1'b1, exp_n[i]}) $display("FAIL wrap_fifo%0d: got %b/%h want 1/%h", i, FoundValid, FoundNonce, exp_n[i]); else n_pass++;
      pop_one();
    end
    n_total++; if ({FoundValid, Overflow} !== 2'b00) $display("FAIL wrap_empty: got fv/ovf %b want 00", {FoundValid, Overflow}); else n_pass++;
  endtask

  task automatic test_overflow();
    bit seen;
    mode   = MODE_ALL;
    Target = 64'h0;
    start_run(64'h100, 64'h105);
    wait_done(seen);
    n_total++; if (Overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", Overflow); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if ({FoundValid, FoundNonce} !== {1'b1, 64'h100 + 64'(i)}) $display("FAIL ovf_fifo%0d: got %b/%h want 1/%h", i, FoundValid, FoundNonce, 64'h100 + 64'(i)); else n_pass++;
      pop_one();
    end
    n_total++; if (FoundValid !== 1'b0) $display("FAIL ovf_empty: got %b want 0", FoundValid); else n_pass++;
    start_run(64'h200, 64'h200);
    n_total++; if (Overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", Overflow); else n_pass++;
    wait_done(seen);
    pop_one();
  endtask

  task automatic test_full_pop();
    bit seen;
    mode   = MODE_ALL;
    Target = 64'h0;
    start_run(64'h300, 64'h304);
    for (int i = 0; i < 394; i++) tick();
    n_total++; if ({FoundValid, FoundNonce} !== {1'b1, 64'h300}) $display("FAIL full_head: got %b/%h want 1/%h", FoundValid, FoundNonce, 64'h300); else n_pass++;
    FoundReady = 1'b1;
    tick();
    FoundReady = 1'b0;
    n_total++; if (Overflow !== 1'b0) $display("FAIL full_pop_ovf: got %b want 0", Overflow); else n_pass++;
    wait_done(seen);
    for (int i = 1; i < 5; i++) begin
      n_total++; if ({FoundValid, FoundNonce} !== {1'b1, 64'h300 + 64'(i)}) $display("FAIL full_fifo%0d: got %b/%h want 1/%h", i, FoundValid, FoundNonce, 64'h300 + 64'(i)); else n_pass++;
      pop_one();
    end
    n_total++; if (FoundValid !== 1'b0) $display("FAIL full_empty: got %b want 0", FoundValid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit seen;
    mode   = MODE_ALL;
    Target = 64'h0;
    start_run(64'h400, 64'h401);
    for (int i = 0; i < 391; i++) tick();
    n_total++; if ({FoundValid, FoundNonce} !== {1'b1, 64'h400}) $display("FAIL b2b_first: got %b/%h want 1/%h", FoundValid, FoundNonce, 64'h400); else n_pass++;
    FoundReady = 1'b1;
    tick();
    FoundReady = 1'b0;
    n_total++; if ({FoundValid, FoundNonce} !== {1'b1, 64'h401}) $display("FAIL b2b_replace: got %b/%h want 1/%h", FoundValid, FoundNonce, 64'h401); else n_pass++;
    wait_done(seen);
    pop_one();
    n_total++; if (FoundValid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", FoundValid); else n_pass++;
  endtask

  task automatic test_target_boundary();
    bit seen;
    mode   = MODE_IDENT;
    Target = 64'h14;
    start_run(64'h12, 64'h16);
    wait_done(seen);
    for (int i = 0; i < 3; i++) begin
      n_total++; if ({FoundValid, FoundNonce} !== {1'b1, 64'h12 + 64'(i)}) $display("FAIL tgt_hit%0d: got %b/%h want 1/%h", i, FoundValid, FoundNonce, 64'h12 + 64'(i)); else n_pass++;
      pop_one();
    end
    n_total++; if (FoundValid !== 1'b0) $display("FAIL tgt_above: got %b want 0", FoundValid); else n_pass++;
  endtask

  task automatic test_stop();
    int busy_cnt;
    int done_cnt;
    mode   = MODE_NONE;
    Target = 64'h0;
    start_run(64'h500, 64'h5FF);
    for (int i = 1; i < 10; i++) begin
      if (i == 4) begin
        NonceStart = 64'hABC;
        Start = 1'b1;
      end
      tick();
      Start = 1'b0;
    end
    n_total++; if ({NonceValid, CurNonce} !== {1'b1, 64'h509}) $display("FAIL stop_pre: got %b/%h want 1/%h", NonceValid, CurNonce, 64'h509); else n_pass++;
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    n_total++; if ({NonceValid, Busy} !== 2'b01) $display("FAIL stop_nv: got nv/busy %b want 01", {NonceValid, Busy}); else n_pass++;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (Busy) busy_cnt++;
      if (Done) done_cnt++;
    end
    n_total++; if (busy_cnt !== 390) $display("FAIL stop_busy: got %0d want 390", busy_cnt); else n_pass++;
    n_total++; if (done_cnt !== 1) $display("FAIL stop_done: got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (FoundValid !== 1'b0) $display("FAIL stop_nohit: got %b want 0", FoundValid); else n_pass++;
  endtask

  task automatic test_start_stop();
    bit seen;
    mode       = MODE_NONE;
    NonceStart = 64'h600;
    NonceEnd   = 64'h602;
    Start      = 1'b1;
    Stop       = 1'b1;
    tick();
    Start = 1'b0;
    Stop  = 1'b0;
    n_total++; if ({NonceValid, CurNonce} !== {1'b1, 64'h600}) $display("FAIL ss_start: got %b/%h want 1/%h", NonceValid, CurNonce, 64'h600); else n_pass++;
    tick();
    tick();
    n_total++; if ({NonceValid, CurNonce} !== {1'b1, 64'h602}) $display("FAIL ss_run: got %b/%h want 1/%h", NonceValid, CurNonce, 64'h602); else n_pass++;
    tick();
    n_total++; if (NonceValid !== 1'b0) $display("FAIL ss_end: got %b want 0", NonceValid); else n_pass++;
    wait_done(seen);
    n_total++; if (seen !== 1'b1) $display("FAIL ss_done: got %b want 1", seen); else n_pass++;
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    n_total++; if ({Busy, NonceValid} !== 2'b00) $display("FAIL ss_idle_stop: got busy/nv %b want 00", {Busy, NonceValid}); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int bad;
    mode   = MODE_ALL;
    Target = 64'h0;
    start_run(64'h700, 64'h7FF);
    for (int i = 0; i < 395; i++) tick();
    n_total++; if (FoundValid !== 1'b1) $display("FAIL mid_pre: got %b want 1", FoundValid); else n_pass++;
    HashRst = 1'b1;
    tick();
    n_total++; if ({CurNonce, NonceValid, FoundValid, FoundNonce, Overflow, Busy, Done} !== '0)
      $display("FAIL mid_rst: got cur %h nv %b fv %b fn %h ovf %b busy %b done %b want all 0", CurNonce, NonceValid, FoundValid, FoundNonce, Overflow, Busy, Done);
    else n_pass++;
    HashRst = 1'b0;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (FoundValid || NonceValid || Busy) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL mid_after: got %0d active cycles want 0", bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_range();
    test_wrap();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_target_boundary();
    test_stop();
    test_start_stop();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
